nocif_dram_write_eg_cpl: RTL

- Write-response egress for the DRAM write path; sits opposite the write ingress that issues AXI AW/W and pushes one context entry per AXI write onto the cq interface.
- Stores per-thread write contexts, consumes AXI B responses, and returns per-client write-complete pulses.
- Returns the completed burst length to ingress on eg2ig_axi_vld/eg2ig_axi_len, which releases write outstanding credit.

---
 rtl/nocif_dram_write_eg_pkg.sv | 15 +
 rtl/nocif_dram_write_eg_ctx_fifo.sv | 38 +++
 rtl/nocif_dram_write_eg_cpl.sv | 101 ++++++++++
 3 files changed

// File: rtl/nocif_dram_write_eg_pkg.sv
// Shared definitions for the DRAM write-response egress.
// Covers the cq payload layout and the per-thread context record.
package nocif_dram_write_eg_pkg;
    localparam int THREAD_ID_W = 4;
    localparam int NUM_TID     = 1 << THREAD_ID_W;
    localparam int REQ_ACK_BIT = 0;
    localparam int LEN_LSB     = 1;
    localparam int LEN_W       = 2;
    localparam int CTX_W       = LEN_W + 1;

    typedef struct packed {
        logic [LEN_W-1:0] axi_len;
        logic             require_ack;
    } ctx_t;
endpackage

// File: rtl/nocif_dram_write_eg_ctx_fifo.sv
// Single-thread register FIFO holding write contexts until their B response.
module nocif_dram_write_eg_ctx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Extra MSB tells a full wrap apart from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/nocif_dram_write_eg_cpl.sv
// Write-response egress: per-thread context FIFOs, B consumption,
// per-client completion pulses and credit return to ingress.
module nocif_dram_write_eg_cpl
    import nocif_dram_write_eg_pkg::*;
#(
    parameter int NUM_CLIENTS = 5,
    parameter int CQ_DEPTH    = 4,
    parameter int AXI_ID_W    = 8
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic                   cq_wr_pvld,
    output logic                   cq_wr_prdy,
    input  logic [3:0]             cq_wr_thread_id,
    input  logic [2:0]             cq_wr_pd,
    input  logic                   noc2mcif_axi_b_bvalid,
    output logic                   noc2mcif_axi_b_bready,
    input  logic [AXI_ID_W-1:0]    noc2mcif_axi_b_bid,
    output logic [NUM_CLIENTS-1:0] mcif2client_wr_rsp_complete,
    output logic                   eg2ig_axi_vld,
    output logic [1:0]             eg2ig_axi_len,
    output logic [8:0]             eg_os_cnt,
    output logic                   eg_err
);
    logic [NUM_CLIENTS-1:0]            full, empty, push_v, pop_v;
    logic [NUM_CLIENTS-1:0][CTX_W-1:0] heads;
    logic [NUM_TID-1:0]                full_pad, empty_pad;
    logic [THREAD_ID_W-1:0]            bt;
    logic                              tid_ok, bt_ok, b_fire, push_any, push_bad, pop_ok;
    ctx_t                              push_ctx, head_sel;
    logic [NUM_CLIENTS-1:0]            cmp_nxt;

    assign full_pad  = NUM_TID'(full);
    assign empty_pad = NUM_TID'(empty);
    assign bt        = noc2mcif_axi_b_bid[THREAD_ID_W-1:0];
    assign tid_ok    = {1'b0, cq_wr_thread_id} < (THREAD_ID_W+1)'(NUM_CLIENTS);
    assign bt_ok     = {1'b0, bt} < (THREAD_ID_W+1)'(NUM_CLIENTS);

    // Out-of-range thread ids are swallowed so ingress never stalls on them.
    assign cq_wr_prdy = tid_ok ? !full_pad[cq_wr_thread_id] : 1'b1;
    assign push_any   = cq_wr_pvld && cq_wr_prdy;
    assign push_bad   = push_any && !tid_ok;

    assign push_ctx.axi_len     = cq_wr_pd[LEN_LSB +: LEN_W];
    assign push_ctx.require_ack = cq_wr_pd[REQ_ACK_BIT];

    assign b_fire = noc2mcif_axi_b_bvalid && noc2mcif_axi_b_bready;
    assign pop_ok = b_fire && bt_ok && !empty_pad[bt];

    always_comb begin
        head_sel = '0;
        push_v   = '0;
        pop_v    = '0;
        cmp_nxt  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (bt == THREAD_ID_W'(i)) head_sel = heads[i];
            push_v[i] = push_any && tid_ok && (cq_wr_thread_id == THREAD_ID_W'(i));
            pop_v[i]  = pop_ok && (bt == THREAD_ID_W'(i));
        end
        for (int i = 0; i < NUM_CLIENTS; i++)
            cmp_nxt[i] = pop_v[i] && head_sel.require_ack;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CLIENTS; g++) begin : g_fifo
            nocif_dram_write_eg_ctx_fifo #(
                .DEPTH (CQ_DEPTH),
                .W     (CTX_W)
            ) u_fifo (
                .clk       (nvdla_core_clk),
                .rst       (nvdla_core_rst),
                .push      (push_v[g]),
                .push_data (push_ctx),
                .pop       (pop_v[g]),
                .full      (full[g]),
                .empty     (empty[g]),
                .head      (heads[g])
            );
        end
    endgenerate

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            noc2mcif_axi_b_bready       <= 1'b0;
            eg2ig_axi_vld               <= 1'b0;
            eg2ig_axi_len               <= '0;
            mcif2client_wr_rsp_complete <= '0;
            eg_os_cnt                   <= '0;
            eg_err                      <= 1'b0;
        end else begin
            noc2mcif_axi_b_bready       <= 1'b1;
            eg2ig_axi_vld               <= pop_ok;
            if (pop_ok) eg2ig_axi_len   <= head_sel.axi_len;
            mcif2client_wr_rsp_complete <= cmp_nxt;
            // Dropped pushes and error pops leave the count untouched.
            eg_os_cnt <= eg_os_cnt + 9'(push_any && tid_ok) - 9'(pop_ok);
            if (push_bad || (b_fire && !pop_ok)) eg_err <= 1'b1;
        end
    end
endmodule
